// File: rtl/mac_seq_pkg.sv
// Shared types and default sizes for the MAC operand sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_seq_pkg;

  localparam int DEF_DW        = 4;   // operand width, matches MAC A/B
  localparam int DEF_OW        = 12;  // MAC accumulated result width
  localparam int DEF_FRAME_LEN = 16;  // operand pairs per MAC run

  typedef enum logic [2:0] {
    FILL   = 3'd0,
    GO     = 3'd1,
    FEED   = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Bundles operand stream, MAC drive/return and result stream of the sequencer.
// Latency: n/a (wires only). SEQ_SHADOW_CHECK_EN adds chk_err.
// Backpressure: in_valid/in_ready and res_valid/res_ready handshakes.
interface mac_operand_sequencer_if
  import mac_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int OW = DEF_OW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          mac_go;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_done;
  logic [OW-1:0] mac_out;
  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;
  logic          res_err;
  logic          busy;
`ifdef SEQ_SHADOW_CHECK_EN
  logic          chk_err;

  modport master (
    input  in_valid, in_a, in_b, mac_done, mac_out, res_ready,
    output in_ready, mac_go, mac_a, mac_b, res_valid, res_data, res_err, busy, chk_err
  );
  modport slave (
    output in_valid, in_a, in_b, mac_done, mac_out, res_ready,
    input  in_ready, mac_go, mac_a, mac_b, res_valid, res_data, res_err, busy, chk_err
  );
`else
  modport master (
    input  in_valid, in_a, in_b, mac_done, mac_out, res_ready,
    output in_ready, mac_go, mac_a, mac_b, res_valid, res_data, res_err, busy
  );
  modport slave (
    output in_valid, in_a, in_b, mac_done, mac_out, res_ready,
    input  in_ready, mac_go, mac_a, mac_b, res_valid, res_data, res_err, busy
  );
`endif
endinterface

// File: rtl/mac_seq_frame_buf.sv
// Register file holding one frame of operand pairs, one write port, one read port.
// Latency: write visible the cycle after wr_en; read is combinational.
// Backpressure: none; the caller only writes while it is filling.
module mac_seq_frame_buf
  import mac_seq_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_FRAME_LEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [DW-1:0] wr_a,
  input  logic [DW-1:0] wr_b,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b
);

  // Contents need no reset: the write pointer decides what is valid.
  logic [2*DW-1:0] mem [DEPTH];

  // Store the pair {a,b} at the write index.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= {wr_a, wr_b};
    end
  end

  assign rd_a = mem[rd_idx][2*DW-1:DW];
  assign rd_b = mem[rd_idx][DW-1:0];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Buffers a frame of operand pairs, feeds them to the MAC, returns its result. SEQ_SHADOW_CHECK_EN adds chk_err.
// Latency: go 1 cycle after last accept; 1+FRAME_LEN*HOLD_CYCLES feed cycles; then wait for done or timeout.
// Backpressure: in_ready only in FILL; result held with res_valid until res_ready.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DW           = DEF_DW,
  parameter int OW           = DEF_OW,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int HOLD_CYCLES  = 3,
  parameter int DONE_TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  mac_operand_sequencer_if.master bus
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int PW = $clog2(FRAME_LEN) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(DONE_TIMEOUT) + 1;

  localparam logic [PW-1:0] LAST_IDX  = PW'(FRAME_LEN - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT   = TW'(DONE_TIMEOUT);

  state_t        state, state_nx;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_idx;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] timer;
  logic [OW-1:0] res_data_q;
  logic          res_err_q;
  logic [DW-1:0] buf_a, buf_b;
  logic [AW-1:0] buf_rd_idx;

  logic accept, handshake, pair_last, wait_done, wait_tmo;

  assign accept    = bus.in_valid && (state == FILL);
  assign handshake = (state == RESULT) && bus.res_ready;
  assign pair_last = (state == FEED) && (hold_cnt == HOLD_LAST) && (rd_idx == LAST_IDX);
  assign wait_done = (state == WAIT) && bus.mac_done;
  // done wins over a coincident timeout
  assign wait_tmo  = (state == WAIT) && !bus.mac_done && (timer == TIMEOUT);

  // GO must show pair 0 even though rd_idx is only cleared on leaving GO.
  assign buf_rd_idx = (state == FEED) ? rd_idx[AW-1:0] : '0;

  mac_seq_frame_buf #(
    .DW    (DW),
    .DEPTH (FRAME_LEN)
  ) u_frame_buf (
    .clk    (clk),
    .wr_en  (accept),
    .wr_idx (wr_ptr[AW-1:0]),
    .wr_a   (bus.in_a),
    .wr_b   (bus.in_b),
    .rd_idx (buf_rd_idx),
    .rd_a   (buf_a),
    .rd_b   (buf_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (accept && (wr_ptr == LAST_IDX)) state_nx = GO;
      GO:      state_nx = FEED;
      FEED:    if (pair_last) state_nx = WAIT;
      WAIT:    if (wait_done || wait_tmo) state_nx = RESULT;
      RESULT:  if (handshake) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Outputs decoded from state; mac_go is additionally blocked while rst is high.
  always_comb begin
    bus.in_ready  = (state == FILL);
    bus.mac_go    = (state == GO) && !rst;
    bus.mac_a     = '0;
    bus.mac_b     = '0;
    if ((state == GO) || (state == FEED)) begin
      bus.mac_a = buf_a;
      bus.mac_b = buf_b;
    end
    bus.res_valid = (state == RESULT);
    bus.res_data  = res_data_q;
    bus.res_err   = res_err_q;
    bus.busy      = (state != FILL);
  end

  // Frame pointers, hold/feed counters, done timer and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_idx     <= '0;
      hold_cnt   <= '0;
      timer      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end else if (handshake) begin
        wr_ptr <= '0;
      end

      if (state == GO) begin
        hold_cnt <= '0;
        rd_idx   <= '0;
      end else if (state == FEED) begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt <= '0;
          rd_idx   <= rd_idx + PW'(1);
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end

      // Leaves WAIT at TIMEOUT at the latest, so the timer never wraps.
      if (state == WAIT) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end

      if (wait_done) begin
        res_data_q <= bus.mac_out;
        res_err_q  <= 1'b0;
      end else if (wait_tmo) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end
    end
  end

`ifdef SEQ_SHADOW_CHECK_EN
  logic [OW-1:0] shadow;
  logic          chk_err_q;

  // Independent running sum of a*b, compared to the MAC result at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (accept) begin
        shadow <= shadow + OW'(bus.in_a) * OW'(bus.in_b);
      end else if (handshake) begin
        shadow <= '0;
      end

      if (wait_done) begin
        chk_err_q <= (bus.mac_out != shadow);
      end else if (wait_tmo) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign bus.chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed-plus-random bench for mac_operand_sequencer against a frame-level reference.
// Latency: checks go timing, per-pair hold, timeout length and handshake turnaround.
// Backpressure: holds res_ready low and keeps in_valid high while the DUT is busy.
module tb_mac_operand_sequencer;
  import mac_seq_pkg::*;

  localparam int FL   = DEF_FRAME_LEN;
  localparam int HOLD = 3;
  localparam int TMO  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_operand_sequencer_if bus ();

  mac_operand_sequencer #(
    .HOLD_CYCLES  (HOLD),
    .DONE_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned pa [FL];
  int unsigned pb [FL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer pairs pa/pb[0..n-1] with random idle gaps; every FILL cycle must show ready and no go.
  task automatic push_pairs(input int n, input bit noise, input string tag);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 4'($urandom);
        if (noise) bus.mac_done = 1'($urandom);
        if (bus.mac_go !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) errs++;
      end
      @(negedge clk);
      if (bus.mac_go !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) errs++;
      bus.in_valid = 1'b1;
      bus.in_a     = 4'(pa[i]);
      bus.in_b     = 4'(pb[i]);
      if (noise) bus.mac_done = 1'($urandom);
    end
    chk({tag, "_fill"}, errs, 0);
  endtask

  // Full frame: push, check go/feed, answer with done after done_dly WAIT cycles
  // (negative = never), hold off res_ready for bp cycles, then hand the result off.
  task automatic run_frame(input int done_dly, input int bp, input int off,
                           input bit noise, input string tag);
    int unsigned ref_sum = 0;
    logic [11:0] exp_data;
    logic        exp_err;
    int          errs;
    int          n;
    for (int i = 0; i < FL; i++) ref_sum += pa[i] * pb[i];

    push_pairs(FL, noise, tag);

    // GO cycle: one-cycle pulse, pair 0 on the bus, extra offered pair refused.
    @(negedge clk);
    bus.in_a = 4'($urandom);
    bus.in_b = 4'($urandom);
    chk({tag, "_go"},       bus.mac_go, 1);
    chk({tag, "_go_rdy"},   bus.in_ready, 0);
    chk({tag, "_go_pair"},  {bus.mac_a, bus.mac_b}, {pa[0][3:0], pb[0][3:0]});

    // FEED: pair k visible for HOLD cycles, no second go, in_valid left high.
    errs = 0;
    for (int c = 0; c < FL * HOLD; c++) begin
      @(negedge clk);
      if (bus.mac_a !== 4'(pa[c / HOLD]) || bus.mac_b !== 4'(pb[c / HOLD])) errs++;
      if (bus.mac_go !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) errs++;
      bus.in_a = 4'($urandom);
      if (noise) bus.mac_done = 1'($urandom);
    end
    chk({tag, "_feed"}, errs, 0);

    // First WAIT cycle.
    @(negedge clk);
    bus.mac_done = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, "_wait_ab"}, {bus.mac_a, bus.mac_b}, 0);

    if (done_dly >= 0) begin
      errs = 0;
      for (int d = 0; d < done_dly; d++) begin
        if (bus.res_valid !== 1'b0) errs++;
        @(negedge clk);
      end
      bus.mac_done = 1'b1;
      bus.mac_out  = 12'(ref_sum + off);
      @(negedge clk);
      bus.mac_done = 1'b0;
      bus.mac_out  = 12'($urandom);
      chk({tag, "_early_res"}, errs, 0);
      exp_data = 12'(ref_sum + off);
      exp_err  = 1'b0;
    end else begin
      n = 0;
      while (bus.res_valid !== 1'b1 && n < 2 * TMO) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_tmo_len"}, n, TMO + 1);
      exp_data = '0;
      exp_err  = 1'b1;
    end

    chk({tag, "_res_vld"},  bus.res_valid, 1);
    chk({tag, "_res_data"}, bus.res_data, exp_data);
    chk({tag, "_res_err"},  bus.res_err, exp_err);
    chk({tag, "_res_rdy"},  bus.in_ready, 0);
`ifdef SEQ_SHADOW_CHECK_EN
    chk({tag, "_chk_err"},  bus.chk_err, (exp_err || off != 0) ? 1 : 0);
`endif

    // Result must stay put while downstream stalls; stray done pulses ignored.
    errs = 0;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      bus.mac_done = 1'($urandom);
      bus.mac_out  = 12'($urandom);
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data ||
          bus.res_err !== exp_err || bus.in_ready !== 1'b0) errs++;
    end
    chk({tag, "_bp"}, errs, 0);

    bus.mac_done  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_hs_vld"}, bus.res_valid, 0);
    chk({tag, "_hs_rdy"}, {bus.in_ready, bus.busy}, 2'b10);
  endtask

  task automatic rand_pairs();
    for (int i = 0; i < FL; i++) begin
      pa[i] = $urandom_range(0, 15);
      pb[i] = $urandom_range(0, 15);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.mac_done  = 1'b0;
    bus.mac_out   = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_go",    bus.mac_go, 0);
    chk("rst_outs",  {bus.in_ready, bus.busy, bus.res_valid, bus.res_err}, 4'b1000);
    chk("rst_ab",    {bus.mac_a, bus.mac_b}, 0);
    chk("rst_data",  bus.res_data, 0);
`ifdef SEQ_SHADOW_CHECK_EN
    chk("rst_chk",   bus.chk_err, 0);
`endif
    rst = 1'b0;

    // A=k, B=1: sum 120, done right away, result taken immediately.
    for (int i = 0; i < FL; i++) begin pa[i] = i; pb[i] = 1; end
    run_frame(0, 0, 0, 1'b0, "ramp");

    // 15*15 everywhere: 3600 fits in 12 bits; downstream stalls 20 cycles.
    for (int i = 0; i < FL; i++) begin pa[i] = 15; pb[i] = 15; end
    run_frame(5, 20, 0, 1'b0, "max");

    // No done ever: timeout path, with done noise outside WAIT.
    rand_pairs();
    run_frame(-1, 3, 0, 1'b1, "tmo");

    // Reset after 7 accepted pairs discards them.
    rand_pairs();
    push_pairs(7, 1'b0, "part");
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {bus.in_ready, bus.busy, bus.mac_go, bus.res_valid}, 4'b1000);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    rand_pairs();
    run_frame($urandom_range(0, 10), 2, 1, 1'b0, "after_rst");

    // Random frames.
    for (int f = 0; f < 3; f++) begin
      rand_pairs();
      run_frame($urandom_range(0, 30), $urandom_range(0, 6), 0, 1'b1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
